// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST response analyzer:
//   - state_e      : analyzer session states
//   - MISR_POLY    : feedback taps for x^8+x^4+x^3+x^2+1
//   - default response/signature widths and the response counter width
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [7:0] MISR_POLY  = 8'h1D;
    localparam int         RESP_W_DEF = 4;
    localparam int         SIG_W_DEF  = 8;
    localparam int         CNT_W      = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

endpackage : bist_pkg

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register. Shifts left with polynomial feedback
// from the MSB and folds in the zero-extended response word.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, loads SEED
//   load    : load SEED (session start); wins over enable
//   enable  : compact data_in into the signature this edge
//   data_in : response word from the circuit under test
//   sig_out : current signature (registered)
// -----------------------------------------------------------------------------
module bist_misr
    import bist_pkg::*;
#(
    parameter int                 RESP_W = RESP_W_DEF,
    parameter int                 SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0]   SEED   = {SIG_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    input  logic [RESP_W-1:0] data_in,
    output logic [SIG_W-1:0]  sig_out
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    // One compaction step: shift, conditional feedback, then fold in the data.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0]  cur,
        input logic [RESP_W-1:0] din
    );
        logic [SIG_W-1:0] fb;
        fb = cur[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        return {cur[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(din);
    endfunction

    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] sig_q;

    // Next signature: load the seed, compact one word, or hold.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (enable) begin
            sig_d = misr_step(sig_q, data_in);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register with synchronous reset to the seed.
    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_out = sig_q;

endmodule : bist_misr

// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
// Compacts a stream of circuit-under-test responses into a MISR signature,
// counts the responses and, after the final one, compares signature and count
// against the fault-free values.
// Ports:
//   clock          : rising-edge clock
//   reset          : synchronous active-high reset
//   testmode       : session enable; low returns to IDLE on the next edge
//   start          : pulse that opens a session from IDLE or DONE
//   resp_valid     : resp_in valid this cycle
//   resp_in        : response word
//   resp_last      : marks the final response of the session
//   resp_ready     : high while compacting
//   signature      : current MISR contents
//   resp_count     : accepted responses, saturating at 255
//   done           : result valid (held in DONE)
//   pass           : signature and count both matched
//   fault_detected : inverse of pass while done, otherwise 0
// -----------------------------------------------------------------------------
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int               RESP_W     = RESP_W_DEF,
    parameter int               SIG_W      = SIG_W_DEF,
    parameter logic [SIG_W-1:0] SEED       = {SIG_W{1'b0}},
    parameter logic [SIG_W-1:0] GOLDEN_SIG = {SIG_W{1'b0}},
    parameter int               N_PATTERNS = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              testmode,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_in,
    input  logic              resp_last,
    output logic              resp_ready,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  resp_count,
    output logic              done,
    output logic              pass,
    output logic              fault_detected
);

    localparam logic [CNT_W-1:0] N_PAT_CNT = CNT_W'(N_PATTERNS);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             done_q;
    logic             done_d;
    logic             pass_q;
    logic             pass_d;
    logic             fault_q;
    logic             fault_d;
    logic             ready_q;
    logic             ready_d;

    logic             accept_s;
    logic             start_ok_s;
    logic             match_s;
    logic [SIG_W-1:0] sig_s;

    // A response is only taken while compacting with the session still enabled,
    // so dropping testmode freezes signature and count on that edge.
    assign accept_s   = (state_q == ST_COMPACT) && resp_valid && testmode;
    assign start_ok_s = start && testmode &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Count is part of the verdict: a short or long session fails even with a
    // matching signature.
    assign match_s    = (sig_s == GOLDEN_SIG) && (count_q == N_PAT_CNT);

    bist_misr #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .SEED   (SEED)
    ) u_misr (
        .clock   (clock),
        .reset   (reset),
        .load    (start_ok_s),
        .enable  (accept_s),
        .data_in (resp_in),
        .sig_out (sig_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; testmode low overrides every transition.
    always_comb begin
        state_d = state_q;
        if (!testmode) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_d = ST_COMPACT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COMPACT: begin
                    if (accept_s && resp_last) begin
                        state_d = ST_COMPARE;
                    end else begin
                        state_d = ST_COMPACT;
                    end
                end
                ST_COMPARE: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (start_ok_s) begin
                        state_d = ST_COMPACT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output/datapath next values: counter, verdict flags and ready.
    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fault_d = fault_q;
        ready_d = (state_d == ST_COMPACT);

        if (start_ok_s) begin
            count_d = {CNT_W{1'b0}};
        end else if (accept_s && (count_q != CNT_MAX)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end

        if (!testmode) begin
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fault_d = 1'b0;
        end else if (state_q == ST_COMPARE) begin
            done_d  = 1'b1;
            pass_d  = match_s;
            fault_d = !match_s;
        end else if (start_ok_s) begin
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fault_d = 1'b0;
        end else begin
            done_d  = done_q;
            pass_d  = pass_q;
            fault_d = fault_q;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fault_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fault_q <= fault_d;
            ready_q <= ready_d;
        end
    end

    assign resp_ready     = ready_q;
    assign signature      = sig_s;
    assign resp_count     = count_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fault_detected = fault_q;

endmodule : bist_response_analyzer

// File: tb/tb_bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_response_analyzer
// Directed, self-checking bench. Expected signature/count are pushed to a
// scoreboard queue when a response is driven and popped after the edge;
// expected verdicts are pushed when resp_last is driven and popped at done.
// -----------------------------------------------------------------------------
module tb_bist_response_analyzer;

    // Reference compaction step for x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [3:0] d);
        logic [7:0] r;
        r = {s[6:0], 1'b0};
        if (s[7]) r = r ^ 8'h1D;
        return r ^ {4'h0, d};
    endfunction

    // Fault-free signature of the seven-word pattern set, first word in the top nibble.
    function automatic logic [7:0] golden_of(input logic [27:0] p);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 6; i >= 0; i--) s = ref_step(s, p[i*4 +: 4]);
        return s;
    endfunction

    localparam logic [27:0] PAT  = 28'h53AF1C7;
    localparam logic [7:0]  GOLD = golden_of(PAT);

    logic       clock = 1'b0;
    logic       reset;
    logic       testmode;
    logic       start;
    logic       resp_valid;
    logic [3:0] resp_in;
    logic       resp_last;
    logic       resp_ready;
    logic [7:0] signature;
    logic [7:0] resp_count;
    logic       done;
    logic       pass;
    logic       fault_detected;

    bist_response_analyzer #(
        .RESP_W     (4),
        .SIG_W      (8),
        .SEED       (8'h00),
        .GOLDEN_SIG (GOLD),
        .N_PATTERNS (7)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .testmode       (testmode),
        .start          (start),
        .resp_valid     (resp_valid),
        .resp_in        (resp_in),
        .resp_last      (resp_last),
        .resp_ready     (resp_ready),
        .signature      (signature),
        .resp_count     (resp_count),
        .done           (done),
        .pass           (pass),
        .fault_detected (fault_detected)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] sig;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] res_q[$];
    logic [7:0] model_sig;
    logic [7:0] model_cnt;
    logic [3:0] pats[7];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_sig = 8'h00;
        model_cnt = 8'h00;
    endtask

    // Drive one accepted response, predict, then compare after the edge.
    task automatic send(input string tag, input logic [3:0] d, input logic last);
        exp_t e;
        resp_valid = 1'b1;
        resp_in    = d;
        resp_last  = last;
        model_sig  = ref_step(model_sig, d);
        if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
        sb_q.push_back({model_sig, model_cnt});
        step();
        resp_valid = 1'b0;
        resp_last  = 1'b0;
        e = sb_q.pop_front();
        chk({tag, "_sig"}, {24'd0, signature}, {24'd0, e.sig});
        chk({tag, "_cnt"}, {24'd0, resp_count}, {24'd0, e.cnt});
    endtask

    // Check the verdict appears exactly one edge after the last response.
    task automatic check_verdict(input string tag);
        logic [1:0] r;
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        step();
        r = res_q.pop_front();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, r[1]});
        chk({tag, "_fault"}, {31'd0, fault_detected}, {31'd0, r[0]});
    endtask

    initial begin
        logic [27:0] pv;
        pv = PAT;
        for (int i = 0; i < 7; i++) pats[i] = pv[(6-i)*4 +: 4];
        reset = 1'b1; testmode = 1'b0; start = 1'b0;
        resp_valid = 1'b0; resp_in = 4'h0; resp_last = 1'b0;
        model_sig = 8'h00; model_cnt = 8'h00;

        // Reset state
        step(); step();
        chk("rst_sig",   {24'd0, signature},  32'h00);
        chk("rst_cnt",   {24'd0, resp_count}, 32'h00);
        chk("rst_done",  {31'd0, done},       32'd0);
        chk("rst_pass",  {31'd0, pass},       32'd0);
        chk("rst_fault", {31'd0, fault_detected}, 32'd0);
        chk("rst_ready", {31'd0, resp_ready}, 32'd0);

        // Two-response session: 0x05 then 0x09, count 2 -> count mismatch
        reset = 1'b0; testmode = 1'b1;
        do_start();
        chk("s1_ready", {31'd0, resp_ready}, 32'd1);
        send("s1_r0", 4'h5, 1'b0);
        chk("s1_sig05", {24'd0, signature}, 32'h05);
        res_q.push_back(2'b01);
        send("s1_r1", 4'h3, 1'b1);
        chk("s1_sig09", {24'd0, signature}, 32'h09);
        chk("s1_ready_cmp", {31'd0, resp_ready}, 32'd0);
        check_verdict("s1");

        // Golden session of seven responses -> pass
        do_start();
        chk("s2_clr_done", {31'd0, done}, 32'd0);
        chk("s2_seed", {24'd0, signature}, 32'h00);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) res_q.push_back(2'b10);
            send("s2", pats[i], (i == 6));
        end
        chk("s2_gold", {24'd0, signature}, {24'd0, GOLD});
        check_verdict("s2");

        // DONE holds; responses and resp_last there are ignored
        resp_valid = 1'b1; resp_in = 4'hF; resp_last = 1'b1;
        step(); step();
        resp_valid = 1'b0; resp_last = 1'b0;
        chk("hold_sig",  {24'd0, signature}, {24'd0, GOLD});
        chk("hold_cnt",  {24'd0, resp_count}, 32'd7);
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_pass", {31'd0, pass}, 32'd1);

        // Bit flip in response 4 -> fail
        do_start();
        for (int i = 0; i < 7; i++) begin
            if (i == 6) res_q.push_back(2'b01);
            send("s3", (i == 3) ? (pats[i] ^ 4'h1) : pats[i], (i == 6));
        end
        check_verdict("s3");

        // Matching data but resp_last on the sixth response -> fault
        do_start();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) res_q.push_back(2'b01);
            send("s4", pats[i], (i == 5));
        end
        check_verdict("s4");

        // testmode low in DONE clears the verdict
        testmode = 1'b0;
        step();
        chk("tm_done",  {31'd0, done}, 32'd0);
        chk("tm_fault", {31'd0, fault_detected}, 32'd0);

        // Feedback path: reach 0x80 then a zero response gives 0x1D
        testmode = 1'b1;
        do_start();
        send("fb_r0", 4'h8, 1'b0);
        for (int i = 0; i < 4; i++) send("fb", 4'h0, 1'b0);
        chk("fb_sig80", {24'd0, signature}, 32'h80);
        send("fb_r5", 4'h0, 1'b0);
        chk("fb_sig1d", {24'd0, signature}, 32'h1D);

        // resp_last without resp_valid, and start in COMPACT, are ignored
        resp_last = 1'b1; start = 1'b1;
        step();
        resp_last = 1'b0; start = 1'b0;
        chk("ign_ready", {31'd0, resp_ready}, 32'd1);
        chk("ign_sig",   {24'd0, signature}, 32'h1D);
        chk("ign_cnt",   {24'd0, resp_count}, 32'd6);

        // testmode dropped mid-COMPACT with valid data -> IDLE, values kept
        testmode = 1'b0; resp_valid = 1'b1; resp_in = 4'h7;
        step();
        resp_valid = 1'b0;
        chk("tmc_ready", {31'd0, resp_ready}, 32'd0);
        chk("tmc_done",  {31'd0, done}, 32'd0);
        chk("tmc_sig",   {24'd0, signature}, 32'h1D);
        chk("tmc_cnt",   {24'd0, resp_count}, 32'd6);

        // resp_valid in IDLE is ignored
        testmode = 1'b1; resp_valid = 1'b1; resp_in = 4'h9;
        step();
        resp_valid = 1'b0;
        chk("idle_sig",   {24'd0, signature}, 32'h1D);
        chk("idle_ready", {31'd0, resp_ready}, 32'd0);

        // Reset mid-COMPACT together with resp_valid and start
        do_start();
        send("rs_r0", 4'h5, 1'b0);
        reset = 1'b1; resp_valid = 1'b1; resp_in = 4'hA; start = 1'b1;
        step();
        reset = 1'b0; resp_valid = 1'b0; start = 1'b0;
        chk("rs_sig",   {24'd0, signature}, 32'h00);
        chk("rs_cnt",   {24'd0, resp_count}, 32'd0);
        chk("rs_ready", {31'd0, resp_ready}, 32'd0);
        resp_valid = 1'b1; resp_in = 4'h3;
        step();
        resp_valid = 1'b0;
        chk("rs_idle_sig", {24'd0, signature}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule : tb_bist_response_analyzer

// File: doc/bist_response_analyzer.md
BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

Interface
REQ-001 Parameter RESP_W, default 4: width of the circuit-under-test response word.
REQ-002 Parameter SIG_W, default 8: MISR signature width.
REQ-003 Parameter SEED, default 8'h00: MISR value loaded on start.
REQ-004 Parameter GOLDEN_SIG, default 8'h00: expected fault-free signature.
REQ-005 Parameter N_PATTERNS, default 7: expected response count per session.
REQ-006 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-007 Port: clock  input  1  rising-edge clock.
REQ-008 Port: reset  input  1  synchronous active-high reset.
REQ-009 Port: testmode  input  1  session enable; low aborts any session.
REQ-010 Port: start  input  1  one-cycle pulse that opens a session.
REQ-011 Port: resp_valid  input  1  resp_in is valid this cycle.
REQ-012 Port: resp_in  input  RESP_W  response word from the circuit under test.
REQ-013 Port: resp_last  input  1  qualifies the final response of the session.
REQ-014 Port: resp_ready  output  1  high only in COMPACT.
REQ-015 Port: signature  output  SIG_W  current MISR contents.
REQ-016 Port: resp_count  output  8  accepted responses, saturating at 255.
REQ-017 Port: done  output  1  result valid, held in DONE.
REQ-018 Port: pass  output  1  signature and count both matched.
REQ-019 Port: fault_detected  output  1  inverse of pass while done is high; 0 otherwise.

Function
REQ-020 States SHALL be IDLE, COMPACT, COMPARE, DONE.
REQ-021 IDLE -> COMPACT on start && testmode; the same edge loads signature=SEED and resp_count=0.
REQ-022 A response SHALL be accepted on an edge where state is COMPACT and resp_valid is high; resp_valid outside COMPACT SHALL be ignored.
REQ-023 Per accepted response: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? 8'h1D : 0) ^ zero-extended resp_in (polynomial x^8+x^4+x^3+x^2+1).
REQ-024 resp_count SHALL increment per accepted response and saturate at 255.
REQ-025 An accepted response with resp_last high SHALL move COMPACT -> COMPARE; resp_last without resp_valid SHALL be ignored.
REQ-026 COMPARE lasts exactly one cycle, then -> DONE; on that edge pass <= (signature==GOLDEN_SIG && resp_count==N_PATTERNS), fault_detected <= !that, done <= 1.
REQ-027 done/pass/fault_detected SHALL therefore be valid on the first edge after the edge that accepts resp_last.
REQ-028 DONE SHALL hold outputs until start (-> COMPACT, clears done/pass/fault_detected, reloads SEED) or testmode low (-> IDLE).
REQ-029 start in COMPACT or COMPARE SHALL be ignored.
REQ-030 testmode low in any state SHALL force IDLE on the next edge with done, pass, fault_detected cleared; signature and resp_count retain their values.
REQ-031 Count mismatch (early or late resp_last, including saturation) SHALL fail even if the signature matches.

Reset
REQ-032 On reset: state=IDLE, signature=SEED, resp_count=0, done=0, pass=0, fault_detected=0, resp_ready=0.
REQ-033 Reset SHALL take priority over start, resp_valid and testmode on the same edge, including mid-session.

Structure
REQ-034 Package bist_pkg SHALL hold the state enum, the MISR polynomial constant 8'h1D and the default widths.
REQ-035 The MISR SHALL be a sub-module bist_misr (load, enable, data_in, sig_out); the FSM, counter and comparison stay in the top module.

Verification
REQ-036 SEED=0; start; responses 4'h5 then 4'h3 (last) -> signature 0x05, then 0x09; resp_count=2.
REQ-037 Signature 0x80, response 4'h0 -> signature 0x1D (feedback path).
REQ-038 GOLDEN_SIG set to the fault-free signature of 7 responses -> done on the edge after last, pass=1, fault_detected=0; flip one bit of response 4 -> pass=0, fault_detected=1.
REQ-039 Matching data with resp_last on the 6th response -> fault_detected=1; testmode dropped mid-COMPACT -> IDLE next edge, done=0.
REQ-040 Reset asserted in COMPACT together with resp_valid -> IDLE, signature=SEED, resp_count=0, no update applied.
